// File: rtl/uart_rx_port_pkg.sv
// Shared definitions for the UART receive port: FSM states and status bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int unsigned ST_VALID    = 0;
  localparam int unsigned ST_OVERRUN  = 1;
  localparam int unsigned ST_FRAMEERR = 2;

endpackage

// File: rtl/uart_rx_port_if.sv
// CPU-side view of the UART receive port: serial line, consume strobe, data and status.
interface uart_rx_port_if;
  logic       rx;
  logic       rd_ack;
  logic [7:0] data_out;
  logic [7:0] status_out;
  logic       busy;

  modport master (
    output rx,
    output rd_ack,
    input  data_out,
    input  status_out,
    input  busy
  );

  modport slave (
    input  rx,
    input  rd_ack,
    output data_out,
    output status_out,
    output busy
  );
endinterface

// File: rtl/uart_rx_port_sync_chain.sv
// Multi-flop synchronizer for asynchronous inputs; flops reset to RESET_VAL.
module sync_chain #(
  parameter int unsigned       WIDTH     = 1,
  parameter int unsigned       STAGES    = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 serial receiver exposing a polled byte/status pair to the CPU input ports.
module uart_rx_port
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_port_if.slave  bus
);

  localparam int unsigned     BW   = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]   FULL = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   ONE  = BW'(1);

  logic rx_s;

  sync_chain #(
    .WIDTH     (1),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (bus.rx),
    .q   (rx_s)
  );

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          ferr_q, ferr_d;
  logic          stop_sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (baud_q == HALF) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          baud_d = baud_q + ONE;
        end
      end
      DATA: begin
        if (baud_q == FULL) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + ONE;
        end
      end
      STOP: begin
        if (baud_q == FULL) begin
          baud_d      = '0;
          stop_sample = 1'b1;
          state_d     = rx_s ? IDLE : BREAK;
        end else begin
          baud_d = baud_q + ONE;
        end
      end
      BREAK: begin
        baud_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A consume strobe is applied first so a same-edge stop sample can override it:
  // a good byte loads over a consumed one, and a framing error always sticks.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;

    if (bus.rd_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      ferr_d    = 1'b0;
    end

    if (stop_sample) begin
      if (rx_s) begin
        if (!valid_q || bus.rd_ack) begin
          data_d    = shift_q;
          valid_d   = 1'b1;
          overrun_d = 1'b0;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  always_comb begin
    bus.status_out              = '0;
    bus.status_out[ST_VALID]    = valid_q;
    bus.status_out[ST_OVERRUN]  = overrun_q;
    bus.status_out[ST_FRAMEERR] = ferr_q;
  end

  assign bus.data_out = data_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_port.sv
// Scoreboard bench for uart_rx_port: stimulus queues expected {data,status} pairs, monitor checks each status change.
module tb_uart_rx_port;

  localparam int unsigned CPB  = 16;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] exp_q [$];

  uart_rx_port_if bus();

  uart_rx_port #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic hold(input logic v, input int unsigned n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
    bus.rx = 1'b1;
  endtask

  task automatic pulse_ack();
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: every change of status_out is one observed response.
  initial begin : monitor
    logic [7:0]  prev = 8'h00;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = bus.status_out;
      end else if (bus.status_out !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_status: got %0h data %0h expected none", bus.status_out, bus.data_out);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", bus.data_out, e[15:8]);
          chk("sb_status", bus.status_out, e[7:0]);
        end
        prev = bus.status_out;
      end
    end
  end

  initial begin : stimulus
    int unsigned n;
    reset      = 1'b1;
    bus.rx     = 1'b1;
    bus.rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", bus.data_out, 8'h00);
    chk("reset_status", bus.status_out, 8'h00);
    chk("reset_busy", bus.busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte with latency bound
    exp_q.push_back({8'hA5, 8'h01});
    fork
      send_frame(8'hA5, 1'b1);
      begin
        n = 0;
        while (n <= 170 && bus.status_out[0] !== 1'b1) begin
          @(negedge clk);
          n++;
        end
        chk("latency_ok", (n >= 153 && n <= 155), 1'b1);
      end
    join
    wait_drain("drain_a5", 20);
    exp_q.push_back({8'hA5, 8'h00});
    pulse_ack();
    wait_drain("drain_ack_a5", 5);
    chk("ack_data_hold", bus.data_out, 8'hA5);

    // Overrun
    exp_q.push_back({8'h3C, 8'h01});
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 4);
    exp_q.push_back({8'h3C, 8'h03});
    send_frame(8'h81, 1'b1);
    hold(1'b1, 4);
    wait_drain("drain_overrun", 20);
    exp_q.push_back({8'h3C, 8'h00});
    pulse_ack();
    wait_drain("drain_ack_ovr", 5);

    // Glitch on the line
    hold(1'b0, 4);
    chk("glitch_busy_high", bus.busy, 1'b1);
    bus.rx = 1'b1;
    n = 0;
    while (n < 8 + SYNC && bus.busy !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    chk("glitch_busy_low", bus.busy, 1'b0);
    hold(1'b1, 4);
    chk("glitch_status", bus.status_out, 8'h00);
    chk("glitch_data", bus.data_out, 8'h3C);

    // Framing error into BREAK, then recovery
    exp_q.push_back({8'h3C, 8'h04});
    send_frame(8'h55, 1'b0);
    hold(1'b0, 40);
    wait_drain("drain_frame", 5);
    chk("break_busy", bus.busy, 1'b1);
    hold(1'b1, 8);
    chk("break_exit", bus.busy, 1'b0);
    exp_q.push_back({8'h12, 8'h05});
    send_frame(8'h12, 1'b1);
    hold(1'b1, 4);
    wait_drain("drain_after_break", 20);
    exp_q.push_back({8'h12, 8'h00});
    pulse_ack();
    wait_drain("drain_ack_ferr", 5);

    // Mid-frame asynchronous reset
    hold(1'b0, 4 * CPB);
    chk("midframe_busy", bus.busy, 1'b1);
    chk("midframe_data", bus.data_out, 8'h12);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_data", bus.data_out, 8'h00);
    chk("async_rst_status", bus.status_out, 8'h00);
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hold(1'b1, 8);
    exp_q.push_back({8'h7E, 8'h01});
    send_frame(8'h7E, 1'b1);
    hold(1'b1, 4);
    wait_drain("drain_7e", 20);
    exp_q.push_back({8'h7E, 8'h00});
    pulse_ack();
    wait_drain("drain_ack_7e", 5);

    // Consume strobe with nothing pending
    pulse_ack();
    hold(1'b1, 3);
    chk("idle_ack_status", bus.status_out, 8'h00);
    chk("idle_ack_data", bus.data_out, 8'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
